// File: rtl/coproc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coproc_pkg
//  Description : Shared types and constants for the coprocessor job scheduler:
//                FSM state encoding, response status codes, opcode/size
//                widths and the reserved (illegal) matrix size code.
//  Revision    : 1.0  initial release
// ============================================================================
package coproc_pkg;

   localparam int OP_W   = 3;
   localparam int SIZE_W = 2;

   // Size code 2'b11 is reserved; jobs carrying it are rejected without launch.
   localparam logic [SIZE_W-1:0] SIZE_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LAUNCH  = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RESPOND = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      RSP_OK      = 2'b00,
      RSP_TIMEOUT = 2'b01,
      RSP_ILLEGAL = 2'b10
   } rsp_status_t;

   function automatic logic size_is_legal(input logic [SIZE_W-1:0] size);
      return (size != SIZE_ILLEGAL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/coproc_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : coproc_scheduler_if
//  Description : Bundle of requester, coprocessor, response and statistics
//                signals around the scheduler. The slave modport is the
//                scheduler's view; the master modport is its environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface coproc_scheduler_if #(
   parameter int CNT_W = 16
);
   import coproc_pkg::*;

   // Requester 0
   logic              req0_valid;
   logic [OP_W-1:0]   req0_op;
   logic [SIZE_W-1:0] req0_size;
   logic              req0_ready;

   // Requester 1
   logic              req1_valid;
   logic [OP_W-1:0]   req1_op;
   logic [SIZE_W-1:0] req1_size;
   logic              req1_ready;

   // Coprocessor side
   logic              cop_start;
   logic [OP_W-1:0]   cop_op;
   logic [SIZE_W-1:0] cop_size;
   logic              cop_sel;
   logic              cop_done;

   // Response side
   logic              rsp_valid;
   logic              rsp_id;
   logic [1:0]        rsp_status;
   logic              rsp_ready;

   // Status and statistics
   logic              busy;
   logic [CNT_W-1:0]  jobs_ok;
   logic [CNT_W-1:0]  jobs_timeout;

   modport slave (
      input  req0_valid, req0_op, req0_size,
      input  req1_valid, req1_op, req1_size,
      input  cop_done, rsp_ready,
      output req0_ready, req1_ready,
      output cop_start, cop_op, cop_size, cop_sel,
      output rsp_valid, rsp_id, rsp_status,
      output busy, jobs_ok, jobs_timeout
   );

   modport master (
      output req0_valid, req0_op, req0_size,
      output req1_valid, req1_op, req1_size,
      output cop_done, rsp_ready,
      input  req0_ready, req1_ready,
      input  cop_start, cop_op, cop_size, cop_sel,
      input  rsp_valid, rsp_id, rsp_status,
      input  busy, jobs_ok, jobs_timeout
   );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin arbiter, purely combinational. A lone
//                request is always granted; on a tie the requester that was
//                not granted last time wins. Grant is one-hot or zero.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2 (
   input  wire logic       valid0_i,
   input  wire logic       valid1_i,
   input  wire logic       last_grant_i,
   output logic [1:0]      grant_o
);

   // Pick a winner: lone requester, or the one opposite last_grant on a tie.
   always_comb begin
      grant_o = 2'b00;
      if (valid0_i && valid1_i) begin
         grant_o = last_grant_i ? 2'b01 : 2'b10;
      end else if (valid0_i) begin
         grant_o = 2'b01;
      end else if (valid1_i) begin
         grant_o = 2'b10;
      end
   end

endmodule
`default_nettype wire

// File: rtl/coproc_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : coproc_scheduler
//  Description : Accepts jobs from two requesters (round-robin), launches one
//                job at a time on a matrix coprocessor, supervises completion
//                with a timeout, and returns a status response. Rejects the
//                reserved size code without launching. Keeps saturating
//                counts of OK and TIMEOUT responses.
//  Revision    : 1.0  initial release
// ============================================================================
module coproc_scheduler
   import coproc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input wire logic          clk,
   input wire logic          reset_n,
   coproc_scheduler_if.slave bus
);

   // Counter only needs to reach TIMEOUT_CYCLES-1.
   localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q,      state_d;
   logic              last_grant_q, last_grant_d;
   logic              cop_start_q,  cop_start_d;
   logic [OP_W-1:0]   cop_op_q,     cop_op_d;
   logic [SIZE_W-1:0] cop_size_q,   cop_size_d;
   logic              cop_sel_q,    cop_sel_d;
   logic              rsp_valid_q,  rsp_valid_d;
   logic              rsp_id_q,     rsp_id_d;
   rsp_status_t       rsp_status_q, rsp_status_d;
   logic              busy_q,       busy_d;
   logic [TMO_W-1:0]  tmo_cnt_q,    tmo_cnt_d;
   logic [CNT_W-1:0]  jobs_ok_q,    jobs_ok_d;
   logic [CNT_W-1:0]  jobs_tmo_q,   jobs_tmo_d;

   logic [1:0]        grant;
   logic              gnt_id;
   logic [OP_W-1:0]   gnt_op;
   logic [SIZE_W-1:0] gnt_size;
   logic              in_idle;

   rr_arbiter2 u_arb (
      .valid0_i     (bus.req0_valid),
      .valid1_i     (bus.req1_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   assign in_idle  = (state_q == ST_IDLE);
   assign gnt_id   = grant[1];
   assign gnt_op   = grant[1] ? bus.req1_op   : bus.req0_op;
   assign gnt_size = grant[1] ? bus.req1_size : bus.req0_size;

   // Ready is the only combinational output; the one-hot grant keeps it exclusive.
   assign bus.req0_ready = in_idle & grant[0];
   assign bus.req1_ready = in_idle & grant[1];

   // Next-state and register-update logic for the job lifecycle.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cop_start_d  = 1'b0;
      cop_op_d     = cop_op_q;
      cop_size_d   = cop_size_q;
      cop_sel_d    = cop_sel_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_status_d = rsp_status_q;
      tmo_cnt_d    = tmo_cnt_q;
      jobs_ok_d    = jobs_ok_q;
      jobs_tmo_d   = jobs_tmo_q;

      case (state_q)
         ST_IDLE: begin
            if (grant != 2'b00) begin
               cop_op_d   = gnt_op;
               cop_size_d = gnt_size;
               cop_sel_d  = gnt_id;
               if (size_is_legal(gnt_size)) begin
                  // Pulse is registered so it lands in the LAUNCH cycle.
                  state_d     = ST_LAUNCH;
                  cop_start_d = 1'b1;
               end else begin
                  state_d      = ST_RESPOND;
                  rsp_valid_d  = 1'b1;
                  rsp_id_d     = gnt_id;
                  rsp_status_d = RSP_ILLEGAL;
               end
            end
         end

         ST_LAUNCH: begin
            tmo_cnt_d = '0;
            state_d   = ST_WAIT;
         end

         ST_WAIT: begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            // Completion is checked first so it wins over a simultaneous expiry.
            if (bus.cop_done) begin
               state_d      = ST_RESPOND;
               rsp_valid_d  = 1'b1;
               rsp_id_d     = cop_sel_q;
               rsp_status_d = RSP_OK;
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d      = ST_RESPOND;
               rsp_valid_d  = 1'b1;
               rsp_id_d     = cop_sel_q;
               rsp_status_d = RSP_TIMEOUT;
            end
         end

         ST_RESPOND: begin
            if (bus.rsp_ready) begin
               state_d      = ST_IDLE;
               rsp_valid_d  = 1'b0;
               last_grant_d = rsp_id_q;
               if (rsp_status_q == RSP_OK && jobs_ok_q != '1) begin
                  jobs_ok_d = jobs_ok_q + CNT_W'(1);
               end
               if (rsp_status_q == RSP_TIMEOUT && jobs_tmo_q != '1) begin
                  jobs_tmo_d = jobs_tmo_q + CNT_W'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State register and all registered outputs; reset drops any in-flight job.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         cop_start_q  <= 1'b0;
         cop_op_q     <= '0;
         cop_size_q   <= '0;
         cop_sel_q    <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_status_q <= RSP_OK;
         busy_q       <= 1'b0;
         tmo_cnt_q    <= '0;
         jobs_ok_q    <= '0;
         jobs_tmo_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cop_start_q  <= cop_start_d;
         cop_op_q     <= cop_op_d;
         cop_size_q   <= cop_size_d;
         cop_sel_q    <= cop_sel_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_status_q <= rsp_status_d;
         busy_q       <= busy_d;
         tmo_cnt_q    <= tmo_cnt_d;
         jobs_ok_q    <= jobs_ok_d;
         jobs_tmo_q   <= jobs_tmo_d;
      end
   end

   assign bus.cop_start    = cop_start_q;
   assign bus.cop_op       = cop_op_q;
   assign bus.cop_size     = cop_size_q;
   assign bus.cop_sel      = cop_sel_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_id       = rsp_id_q;
   assign bus.rsp_status   = rsp_status_q;
   assign bus.busy         = busy_q;
   assign bus.jobs_ok      = jobs_ok_q;
   assign bus.jobs_timeout = jobs_tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_coproc_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coproc_scheduler
//  Description : Directed bench for coproc_scheduler with a job-level
//                reference model (cycle arithmetic per job) checked every
//                cycle, plus literal expectations for each scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_coproc_scheduler;

   localparam int T    = 8;
   localparam int CW   = 2;
   localparam int MAXC = (1 << CW) - 1;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   coproc_scheduler_if #(.CNT_W(CW)) bus ();

   coproc_scheduler #(
      .TIMEOUT_CYCLES (T),
      .CNT_W          (CW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- job-level reference model ----------------
   int         cyc       = 0;
   bit         cmp_en    = 1'b0;
   bit         m_active  = 1'b0;
   int         m_acc     = 0;
   int         m_rsp_cyc = -1;   // cycle in which the response becomes visible
   bit         m_id      = 1'b0;
   logic [2:0] m_op      = '0;
   logic [1:0] m_size    = '0;
   logic [1:0] m_status  = '0;
   bit         m_last    = 1'b1;
   bit         m_rid     = 1'b0; // last handshaken response id
   logic [1:0] m_rstat   = '0;
   int         m_ok      = 0;
   int         m_tmo     = 0;

   // Observation helpers for the literal checks.
   bit         gq[$];
   int         n_both  = 0;
   int         n_start = 0;

   always @(negedge clk) begin
      bit e0, e1, ev, es;
      e0 = 1'b0;
      e1 = 1'b0;
      if (!m_active) begin
         if (bus.req0_valid && bus.req1_valid) begin
            if (m_last) e0 = 1'b1; else e1 = 1'b1;
         end else if (bus.req0_valid) begin
            e0 = 1'b1;
         end else if (bus.req1_valid) begin
            e1 = 1'b1;
         end
      end
      ev = m_active && (m_rsp_cyc >= 0) && (cyc >= m_rsp_cyc);
      es = m_active && (m_size != 2'b11) && (cyc == m_acc + 1);

      if (cmp_en) begin
         chk("req0_ready",   bus.req0_ready, e0);
         chk("req1_ready",   bus.req1_ready, e1);
         chk("busy",         bus.busy, m_active);
         chk("cop_start",    bus.cop_start, es);
         chk("cop_op",       bus.cop_op, m_op);
         chk("cop_size",     bus.cop_size, m_size);
         chk("cop_sel",      bus.cop_sel, m_id);
         chk("rsp_valid",    bus.rsp_valid, ev);
         chk("rsp_id",       bus.rsp_id, ev ? m_id : m_rid);
         chk("rsp_status",   bus.rsp_status, ev ? m_status : m_rstat);
         chk("jobs_ok",      bus.jobs_ok, m_ok);
         chk("jobs_timeout", bus.jobs_timeout, m_tmo);
      end

      if (bus.req0_ready) gq.push_back(1'b0);
      if (bus.req1_ready) gq.push_back(1'b1);
      if (bus.req0_ready && bus.req1_ready) n_both++;
      if (bus.cop_start) n_start++;

      // Advance the model with this cycle's inputs.
      if (!reset_n) begin
         m_active = 1'b0; m_last = 1'b1; m_op = '0; m_size = '0; m_id = 1'b0;
         m_rid = 1'b0; m_rstat = '0; m_ok = 0; m_tmo = 0; m_rsp_cyc = -1;
      end else if (!m_active) begin
         if (e0 || e1) begin
            m_active = 1'b1;
            m_acc    = cyc;
            m_id     = e1;
            m_op     = e1 ? bus.req1_op   : bus.req0_op;
            m_size   = e1 ? bus.req1_size : bus.req0_size;
            if (m_size == 2'b11) begin
               m_rsp_cyc = cyc + 1;
               m_status  = 2'b10;
            end else begin
               m_rsp_cyc = -1;
            end
         end
      end else if (m_rsp_cyc < 0) begin
         if (cyc >= m_acc + 2) begin
            if (bus.cop_done) begin
               m_rsp_cyc = cyc + 1;
               m_status  = 2'b00;
            end else if (cyc == m_acc + 2 + T - 1) begin
               m_rsp_cyc = cyc + 1;
               m_status  = 2'b01;
            end
         end
      end else if (cyc >= m_rsp_cyc && bus.rsp_ready) begin
         m_active = 1'b0;
         m_last   = m_id;
         m_rid    = m_id;
         m_rstat  = m_status;
         if (m_status == 2'b00 && m_ok  < MAXC) m_ok++;
         if (m_status == 2'b01 && m_tmo < MAXC) m_tmo++;
      end
      cyc++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int k;
      bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_size = '0;
      bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_size = '0;
      bus.cop_done   = 1'b0; bus.rsp_ready = 1'b0;

      reset_n = 1'b0;
      repeat (3) step();
      cmp_en = 1'b1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_jobs_ok", bus.jobs_ok, 0);
      reset_n = 1'b1;
      step();

      // Single OK job from requester 0, done in the 4th WAIT cycle.
      n_start = 0;
      bus.req0_valid = 1'b1; bus.req0_op = 3'd3; bus.req0_size = 2'd2;
      #1 chk("A_ready0", bus.req0_ready, 1);
      step(); bus.req0_valid = 1'b0;
      chk("A_start", bus.cop_start, 1);
      chk("A_sel", bus.cop_sel, 0);
      chk("A_op", bus.cop_op, 3);
      repeat (3) step();
      step(); bus.cop_done = 1'b1;
      step(); bus.cop_done = 1'b0;
      chk("A_rsp_valid", bus.rsp_valid, 1);
      chk("A_rsp_id", bus.rsp_id, 0);
      chk("A_rsp_status", bus.rsp_status, 0);
      bus.rsp_ready = 1'b1;
      step(); bus.rsp_ready = 1'b0;
      chk("A_jobs_ok", bus.jobs_ok, 1);
      chk("A_busy", bus.busy, 0);
      chk("A_one_start", n_start, 1);

      // Fresh reset, then both requesters valid for four back-to-back jobs.
      reset_n = 1'b0;
      repeat (2) step();
      reset_n = 1'b1;
      gq.delete(); n_both = 0;
      bus.req0_valid = 1'b1; bus.req0_op = 3'd1; bus.req0_size = 2'd0;
      bus.req1_valid = 1'b1; bus.req1_op = 3'd5; bus.req1_size = 2'd1;
      bus.cop_done = 1'b1; bus.rsp_ready = 1'b1;
      repeat (16) step();
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.cop_done = 1'b0; bus.rsp_ready = 1'b0;
      chk("B_grant_count", gq.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("B_grant_seq", (gq.size() > i) ? 32'(gq[i]) : 32'd2, 32'(i % 2));
      end
      chk("B_never_both", n_both, 0);
      chk("B_jobs_ok_sat", bus.jobs_ok, 3);
      step();

      // Timeout: no completion; late cop_done during RESPOND is ignored.
      bus.req0_valid = 1'b1; bus.req0_op = 3'd2; bus.req0_size = 2'd1;
      step(); bus.req0_valid = 1'b0;
      step();
      k = 0;
      while (!bus.rsp_valid && k < 20) begin
         step();
         k++;
      end
      chk("C_tmo_latency", k, 8);
      chk("C_status", bus.rsp_status, 1);
      bus.cop_done = 1'b1;
      step(); bus.cop_done = 1'b0;
      chk("C_late_done_status", bus.rsp_status, 1);
      bus.rsp_ready = 1'b1;
      step(); bus.rsp_ready = 1'b0;
      chk("C_jobs_timeout", bus.jobs_timeout, 1);
      chk("C_jobs_ok", bus.jobs_ok, 3);

      // Illegal size from requester 1: no launch, immediate response.
      n_start = 0;
      bus.req1_valid = 1'b1; bus.req1_op = 3'd6; bus.req1_size = 2'b11;
      #1 chk("D_ready1", bus.req1_ready, 1);
      step(); bus.req1_valid = 1'b0;
      chk("D_rsp_valid", bus.rsp_valid, 1);
      chk("D_rsp_id", bus.rsp_id, 1);
      chk("D_rsp_status", bus.rsp_status, 2);
      bus.rsp_ready = 1'b1;
      step(); bus.rsp_ready = 1'b0;
      chk("D_no_start", n_start, 0);
      chk("D_jobs_ok", bus.jobs_ok, 3);
      chk("D_jobs_timeout", bus.jobs_timeout, 1);

      // Response back-pressure for 5 cycles with req0 still asking.
      bus.req0_valid = 1'b1; bus.req0_op = 3'd4; bus.req0_size = 2'd0;
      step();
      step(); bus.cop_done = 1'b1;
      step(); bus.cop_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("E_hold_ready0", bus.req0_ready, 0);
         chk("E_hold_valid", bus.rsp_valid, 1);
         chk("E_hold_status", bus.rsp_status, 0);
         step();
      end
      bus.req0_valid = 1'b0; bus.rsp_ready = 1'b1;
      step(); bus.rsp_ready = 1'b0;

      // Reset during WAIT drops the job and restores reset values.
      bus.req1_valid = 1'b1; bus.req1_op = 3'd7; bus.req1_size = 2'd2;
      step(); bus.req1_valid = 1'b0;
      step();
      step(); reset_n = 1'b0;
      step(); reset_n = 1'b1;
      chk("E_rst_busy", bus.busy, 0);
      chk("E_rst_start", bus.cop_start, 0);
      chk("E_rst_rsp_valid", bus.rsp_valid, 0);
      chk("E_rst_rsp_id", bus.rsp_id, 0);
      chk("E_rst_status", bus.rsp_status, 0);
      chk("E_rst_op", bus.cop_op, 0);
      chk("E_rst_size", bus.cop_size, 0);
      chk("E_rst_sel", bus.cop_sel, 0);
      chk("E_rst_jobs_ok", bus.jobs_ok, 0);
      chk("E_rst_jobs_tmo", bus.jobs_timeout, 0);
      step();

      // First tie after reset goes to requester 0.
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      #1 chk("E_tie_ready0", bus.req0_ready, 1);
      chk("E_tie_ready1", bus.req1_ready, 0);
      step();
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
